// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the five-stage datapath and the hazard/stall scheduler.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  // ID-stage decode info and pipeline events
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_wen;
  logic             id_load;
  logic             id_mem;
  logic             ex_brn_tkn;
  logic             mem_ack;

  // Pipeline controls and status
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_wen, id_load, id_mem, ex_brn_tkn, mem_ack,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
           mem_err, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_wen, id_load, id_mem, ex_brn_tkn, mem_ack,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
           mem_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/stall scheduler: shadows EX/MEM/WB register usage and drives PC/IF-ID
// enables, bubble/flush, ALU forwarding selects and the data-memory freeze.
// MEM/WB shadows keep only the fields their hazard checks actually read.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic           clock,
  input  logic           reset,
  pipeline_ctrl_if.slave bus
);
  localparam int unsigned REG_W  = 5;
  localparam int unsigned FWD_W  = 2;
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic             valid;
    logic             wen;
    logic [REG_W-1:0] rd;
  } dst_t;

  typedef struct packed {
    dst_t             dst;
    logic             load;
    logic             mem;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             use1;
    logic             use2;
  } shadow_t;

  state_t            state_q, state_d;
  shadow_t           id_entry, ex_q;
  dst_t              mem_dst_q, wb_dst_q;
  logic              mem_acc_q;
  logic              flush_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              mem_err_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic              mem_miss, load_use, freeze;
  logic              pc_en, if_id_en, flush, bubble;
  logic [FWD_W-1:0]  fwd_a, fwd_b;

  // Producer d writes the register consumed as rs; x0 never matches.
  function automatic logic hazard(dst_t d, logic [REG_W-1:0] rs, logic use_rs);
    return d.valid && d.wen && (d.rd != '0) && (d.rd == rs) && use_rs;
  endfunction

  // Youngest producer wins: MEM before WB, otherwise the register file.
  function automatic logic [FWD_W-1:0] fwd_sel(logic ex_valid, logic [REG_W-1:0] rs,
                                                logic use_rs, dst_t m, dst_t w);
    if (!ex_valid)           return FWD_RF;
    if (hazard(m, rs, use_rs)) return FWD_MEM;
    if (hazard(w, rs, use_rs)) return FWD_WB;
    return FWD_RF;
  endfunction

  // ID instruction as it would enter EX; the slot behind a redirect is squashed.
  always_comb begin
    id_entry           = '0;
    id_entry.dst.valid = bus.id_valid & ~flush_q;
    id_entry.dst.wen   = bus.id_wen;
    id_entry.dst.rd    = bus.id_rd;
    id_entry.load      = bus.id_load;
    id_entry.mem       = bus.id_mem;
    id_entry.rs1       = bus.id_rs1;
    id_entry.rs2       = bus.id_rs2;
    id_entry.use1      = bus.id_use_rs1;
    id_entry.use2      = bus.id_use_rs2;
  end

  // Load in EX feeding the instruction in ID.
  always_comb begin
    load_use = ex_q.load && id_entry.dst.valid &&
               (hazard(ex_q.dst, bus.id_rs1, bus.id_use_rs1) ||
                hazard(ex_q.dst, bus.id_rs2, bus.id_use_rs2));
  end

  // Next state and pipeline controls: memory freeze > redirect > load-use.
  always_comb begin
    state_d  = state_q;
    pc_en    = 1'b1;
    if_id_en = 1'b1;
    flush    = 1'b0;
    bubble   = 1'b0;
    freeze   = 1'b0;
    mem_miss = mem_dst_q.valid && mem_acc_q && !bus.mem_ack;

    case (state_q)
      RUN:      if (mem_miss)    state_d = MEM_WAIT;
      MEM_WAIT: if (bus.mem_ack) state_d = RUN;
      default:                   state_d = RUN;
    endcase

    if (mem_miss) begin
      freeze   = 1'b1;
      pc_en    = 1'b0;
      if_id_en = 1'b0;
    end else if (bus.ex_brn_tkn) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (load_use) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      bubble   = 1'b1;
    end

    if (reset) begin
      state_d  = RUN;
      pc_en    = 1'b1;
      if_id_en = 1'b1;
      flush    = 1'b0;
      bubble   = 1'b0;
      freeze   = 1'b0;
    end
  end

  // Forwarding selects for the instruction currently in EX.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!reset) begin
      fwd_a = fwd_sel(ex_q.dst.valid, ex_q.rs1, ex_q.use1, mem_dst_q, wb_dst_q);
      fwd_b = fwd_sel(ex_q.dst.valid, ex_q.rs2, ex_q.use2, mem_dst_q, wb_dst_q);
    end
  end

  // FSM state and shadow pipeline; everything holds while frozen.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      ex_q      <= '0;
      mem_dst_q <= '0;
      mem_acc_q <= 1'b0;
      wb_dst_q  <= '0;
      flush_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!freeze) begin
        wb_dst_q  <= mem_dst_q;
        mem_dst_q <= ex_q.dst;
        mem_acc_q <= ex_q.mem;
        ex_q      <= bubble ? '0 : id_entry;
        flush_q   <= flush;
      end
    end
  end

  // Wait-cycle counter and sticky timeout flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else if (state_q == MEM_WAIT && !bus.mem_ack) begin
      if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT)) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      if (wait_cnt_q >= WAIT_W'(MEM_TIMEOUT - 1)) mem_err_q <= 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (!pc_en && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = flush;
  assign bus.id_ex_bubble = bubble;
  assign bus.fwd_a        = fwd_a;
  assign bus.fwd_b        = fwd_b;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a per-cycle vector table for forwarding,
// load-use and redirect cases, then hand sequences for memory wait and timeout.
module tb_pipeline_ctrl;
  localparam int unsigned CNT_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst, iv;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, wen, ld, mem, brn, ack;
  } in_t;

  typedef struct {
    logic       pc, ifid, fl, bb;
    logic [1:0] fa, fb;
    logic [3:0] sc;
    logic       err;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  vec_t tbl[26];

  function automatic in_t ins(int iv, int rd, int rs1, int rs2, int u1, int u2,
                              int wen, int ld, int mem);
    in_t r;
    r.rst = 1'b0; r.iv = 1'(iv); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
    r.u1 = 1'(u1); r.u2 = 1'(u2); r.wen = 1'(wen); r.ld = 1'(ld); r.mem = 1'(mem);
    r.brn = 1'b0; r.ack = 1'b1;
    return r;
  endfunction

  function automatic in_t nop();                   return ins(0, 0, 0, 0, 0, 0, 0, 0, 0);     endfunction
  function automatic in_t add(int rd, int a, int b); return ins(1, rd, a, b, 1, 1, 1, 0, 0);  endfunction
  function automatic in_t addi(int rd, int a);     return ins(1, rd, a, 0, 1, 0, 1, 0, 0);    endfunction
  function automatic in_t lw(int rd, int a);       return ins(1, rd, a, 0, 1, 0, 1, 1, 1);    endfunction
  function automatic in_t sw(int a, int b);        return ins(1, 0, a, b, 1, 1, 0, 0, 1);     endfunction
  function automatic in_t br(in_t x);     x.brn = 1'b1; return x; endfunction
  function automatic in_t nack(in_t x);   x.ack = 1'b0; return x; endfunction
  function automatic in_t rst_on(in_t x); x.rst = 1'b1; return x; endfunction

  function automatic exp_t ex(int pc, int ifid, int fl, int bb, int fa, int fb, int sc);
    exp_t r;
    r.pc = 1'(pc); r.ifid = 1'(ifid); r.fl = 1'(fl); r.bb = 1'(bb);
    r.fa = 2'(fa); r.fb = 2'(fb); r.sc = 4'(sc); r.err = 1'b0;
    return r;
  endfunction

  function automatic exp_t run(int fa, int fb, int sc); return ex(1, 1, 0, 0, fa, fb, sc); endfunction
  function automatic exp_t stl(int fa, int fb, int sc); return ex(0, 0, 0, 1, fa, fb, sc); endfunction
  function automatic exp_t brx(int fa, int fb, int sc); return ex(1, 1, 1, 1, fa, fb, sc); endfunction
  function automatic exp_t frz(int fa, int fb, int sc); return ex(0, 0, 0, 0, fa, fb, sc); endfunction

  function automatic vec_t mkv(in_t i, exp_t e);
    vec_t v;
    v.i = i; v.e = e;
    return v;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic apply(in_t v);
    reset          = v.rst;
    bus.id_valid   = v.iv;
    bus.id_rd      = v.rd;
    bus.id_rs1     = v.rs1;
    bus.id_rs2     = v.rs2;
    bus.id_use_rs1 = v.u1;
    bus.id_use_rs2 = v.u2;
    bus.id_wen     = v.wen;
    bus.id_load    = v.ld;
    bus.id_mem     = v.mem;
    bus.ex_brn_tkn = v.brn;
    bus.mem_ack    = v.ack;
  endtask

  task automatic check_all(string tag, exp_t e);
    chk({tag, " pc_en"},        16'(bus.pc_en),        16'(e.pc));
    chk({tag, " if_id_en"},     16'(bus.if_id_en),     16'(e.ifid));
    chk({tag, " if_id_flush"},  16'(bus.if_id_flush),  16'(e.fl));
    chk({tag, " id_ex_bubble"}, 16'(bus.id_ex_bubble), 16'(e.bb));
    chk({tag, " fwd_a"},        16'(bus.fwd_a),        16'(e.fa));
    chk({tag, " fwd_b"},        16'(bus.fwd_b),        16'(e.fb));
    chk({tag, " stall_cnt"},    16'(bus.stall_cnt),    16'(e.sc));
    chk({tag, " mem_err"},      16'(bus.mem_err),      16'(e.err));
  endtask

  // Drive one cycle of inputs, check mid-cycle, then let the edge land.
  task automatic step(string tag, in_t v, exp_t e);
    apply(v);
    @(negedge clock);
    check_all(tag, e);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    apply(rst_on(nop()));
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Row r: EX holds ID of row r-1, MEM of r-2, WB of r-3 unless stalled/squashed.
    tbl[0]  = mkv(rst_on(nop()),       run(0, 0, 0));
    tbl[1]  = mkv(add(5, 1, 2),        run(0, 0, 0));
    tbl[2]  = mkv(add(6, 5, 5),        run(0, 0, 0));
    tbl[3]  = mkv(add(10, 3, 4),       run(1, 1, 0));  // x5 in MEM
    tbl[4]  = mkv(add(11, 6, 10),      run(0, 0, 0));
    tbl[5]  = mkv(add(0, 1, 2),        run(2, 1, 0));  // x6 in WB, x10 in MEM
    tbl[6]  = mkv(add(12, 0, 0),       run(0, 0, 0));
    tbl[7]  = mkv(add(13, 1, 1),       run(0, 0, 0));  // x0 writer never forwards
    tbl[8]  = mkv(add(13, 2, 2),       run(0, 0, 0));
    tbl[9]  = mkv(add(14, 13, 12),     run(0, 0, 0));
    tbl[10] = mkv(nop(),               run(1, 0, 0));  // x13 in MEM and WB: MEM wins
    tbl[11] = mkv(addi(15, 14),        run(0, 0, 0));
    tbl[12] = mkv(nop(),               run(2, 0, 0));  // rs2 not used
    tbl[13] = mkv(lw(7, 1),            run(0, 0, 0));
    tbl[14] = mkv(add(8, 7, 1),        stl(0, 0, 0));  // load-use
    tbl[15] = mkv(add(8, 7, 1),        run(0, 0, 1));
    tbl[16] = mkv(lw(7, 1),            run(2, 0, 1));  // load result from MEM/WB
    tbl[17] = mkv(add(8, 1, 2),        run(0, 0, 1));  // independent: no stall
    tbl[18] = mkv(nop(),               run(0, 0, 1));
    tbl[19] = mkv(br(add(20, 1, 2)),   brx(0, 0, 1));
    tbl[20] = mkv(lw(21, 1),           run(0, 0, 1));  // wrong-path slot, squashed
    tbl[21] = mkv(add(22, 21, 21),     run(0, 0, 1));  // would stall if lw survived
    tbl[22] = mkv(lw(23, 1),           run(0, 0, 1));
    tbl[23] = mkv(br(add(24, 23, 1)),  brx(0, 0, 1));  // redirect beats load-use
    tbl[24] = mkv(nop(),               run(0, 0, 1));
    tbl[25] = mkv(nop(),               run(0, 0, 1));

    do_reset();
    for (int i = 0; i < 26; i++) step($sformatf("row%0d", i), tbl[i].i, tbl[i].e);

    // Store waits three cycles in MEM; pipeline frozen, then resumes intact.
    do_reset();
    step("t5 c0",  sw(1, 2),               run(0, 0, 0));
    step("t5 c1",  add(30, 1, 2),          run(0, 0, 0));
    step("t5 c2",  nack(add(31, 30, 30)),  frz(0, 0, 0));
    step("t5 c3",  nack(add(31, 30, 30)),  frz(0, 0, 1));
    step("t5 c4",  nack(add(31, 30, 30)),  frz(0, 0, 2));
    step("t5 c5",  add(31, 30, 30),        run(0, 0, 3));
    step("t5 c6",  nop(),                  run(1, 1, 3));
    // Redirect held during a wait is acted on only in the release cycle.
    step("t5 c7",  sw(1, 2),               run(0, 0, 3));
    step("t5 c8",  nop(),                  run(0, 0, 3));
    step("t5 c9",  nack(br(nop())),        frz(0, 0, 3));
    step("t5 c10", nack(br(nop())),        frz(0, 0, 4));
    step("t5 c11", br(nop()),              brx(0, 0, 5));

    // Ack never arrives: mem_err after four wait cycles, stall_cnt saturates.
    do_reset();
    step("t6 c0", sw(1, 2), run(0, 0, 0));
    step("t6 c1", nop(),    run(0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      exp_t e;
      e = frz(0, 0, (i < 15) ? i : 15);
      e.err = (i >= 5);
      step($sformatf("t6 w%0d", i), nack(nop()), e);
    end
    apply(rst_on(nack(nop())));
    @(posedge clock);
    #1;
    step("t6 post", nack(nop()), run(0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
